// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions used by the CSR master and the CSR slave.
//   resp_t       : BRESP/RRESP encodings
//   mst_state_t  : axi_lite_master transaction state
//   PROT_DEFAULT : AxPROT value driven on every request
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } mst_state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a cmd/rsp valid-ready pair.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_*                 : request in (write flag, address, data, strobes)
//   rsp_*                 : response out (read data, BRESP/RRESP, watchdog flag)
//   busy                  : a transaction is in flight or awaiting rsp_ready
//   m_axi_*               : AXI4-Lite master channels AW/W/B/AR/R
// A watchdog aborts a transaction that stalls for TIMEOUT_CYCLES cycles
// (0 disables it) and returns SLVERR with rsp_timeout set.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp
);

  localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  mst_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic bready_q, bready_d, rready_q, rready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [1:0]              rsp_resp_q,  rsp_resp_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CW-1:0]           wd_cnt_q,    wd_cnt_d;

  logic aw_hs, w_hs, aw_fin, w_fin, wd_expire, timeout_hit;

  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q & m_axi_wready;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;
  // Counter holds the number of wait cycles already spent, so expiry on
  // LIMIT ends the transaction after exactly TIMEOUT_CYCLES wait cycles.
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == CW'(LIMIT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a completing handshake takes priority over expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (cmd_valid) state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if (aw_fin && w_fin) state_d = ST_WR_RESP;
                  else if (wd_expire)  state_d = ST_RSP;
      ST_WR_RESP: if (m_axi_bvalid || wd_expire) state_d = ST_RSP;
      ST_RD_REQ:  if (m_axi_arready) state_d = ST_RD_RESP;
                  else if (wd_expire) state_d = ST_RSP;
      ST_RD_RESP: if (m_axi_rvalid || wd_expire) state_d = ST_RSP;
      ST_RSP:     if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_hit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wd_cnt_d = '0;
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR_REQ: begin
        wd_cnt_d = wd_cnt_q + CW'(1);
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) bready_d    = 1'b1;
        else if (wd_expire)  timeout_hit = 1'b1;
      end
      ST_WR_RESP: begin
        wd_cnt_d = wd_cnt_q + CW'(1);
        if (m_axi_bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
        end else if (wd_expire) begin
          timeout_hit = 1'b1;
        end
      end
      ST_RD_REQ: begin
        wd_cnt_d = wd_cnt_q + CW'(1);
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (wd_expire) begin
          timeout_hit = 1'b1;
        end
      end
      ST_RD_RESP: begin
        wd_cnt_d = wd_cnt_q + CW'(1);
        if (m_axi_rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi_rresp;
          rsp_rdata_d   = m_axi_rdata;
          rsp_timeout_d = 1'b0;
        end else if (wd_expire) begin
          timeout_hit = 1'b1;
        end
      end
      ST_RSP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
    if (timeout_hit) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = RESP_SLVERR;
      rsp_rdata_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_resp_q    <= '0;
      rsp_rdata_q   <= '0;
      wd_cnt_q      <= '0;
    end else begin
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_rready  = rready_q;

endmodule
